// File: rtl/video_fx_pkg.sv
// video_fx_pkg
// Shared definitions for the video effect chain: raster geometry, field widths,
// the per-sample beat struct used by the multi-mux and every effect stage, and
// the helpers the crush (mosaic/posterize) stage uses for its frame parameters.
package video_fx_pkg;

    localparam int H_ACTIVE = 1280;
    localparam int V_ACTIVE = 720;
    localparam int PIX_W    = 24;
    localparam int HC_W     = 11;
    localparam int VC_W     = 10;
    localparam int SH_W     = 3;
    localparam int CB_W     = 4;

    localparam logic [SH_W-1:0] SH_MAX = 3'd5;

    // One raster sample as it travels between effect stages.
    typedef struct packed {
        logic [HC_W-1:0]  h_count;
        logic [VC_W-1:0]  v_count;
        logic             active_draw;
        logic [PIX_W-1:0] pixel;
    } video_beat_t;

    // Pipeline payload inside the mosaic stage. use_buf marks a repeated row
    // whose output comes from the line buffer instead of src.
    typedef struct packed {
        video_beat_t      beat;
        logic [PIX_W-1:0] src;
        logic             use_buf;
        logic [CB_W-1:0]  cb;
    } mosaic_stage_t;

    // Block edges beyond 32 pixels are not supported; larger requests saturate.
    function automatic logic [SH_W-1:0] clamp_shift(input logic [SH_W-1:0] s);
        return (s > SH_MAX) ? SH_MAX : s;
    endfunction

    // A colour depth of 0 encodes the full 8 bits.
    function automatic logic [CB_W-1:0] decode_bits(input logic [2:0] b);
        return (b == 3'd0) ? 4'd8 : {1'b0, b};
    endfunction

    // Keep the top cb bits of each 8-bit channel.
    function automatic logic [PIX_W-1:0] quantize(input logic [PIX_W-1:0] p,
                                                  input logic [CB_W-1:0]  cb);
        logic [7:0] m;
        m = 8'hFF << (4'd8 - cb);
        return p & {m, m, m};
    endfunction

endpackage

// File: rtl/video_mosaic_fx_if.sv
// video_mosaic_fx_if
// Raster stream into and out of the crush effect, plus its two frame
// parameters.
//   master : drives block_shift, color_bits and the input stream;
//            observes the output stream.
//   slave  : the effect stage itself.
interface video_mosaic_fx_if;
    import video_fx_pkg::*;

    logic [SH_W-1:0]  block_shift;
    logic [2:0]       color_bits;

    logic [HC_W-1:0]  h_count_in;
    logic [VC_W-1:0]  v_count_in;
    logic             active_draw_in;
    logic [PIX_W-1:0] pixel_in;

    logic [HC_W-1:0]  h_count_out;
    logic [VC_W-1:0]  v_count_out;
    logic             active_draw_out;
    logic [PIX_W-1:0] pixel_out;

    modport master (
        output block_shift, color_bits,
        output h_count_in, v_count_in, active_draw_in, pixel_in,
        input  h_count_out, v_count_out, active_draw_out, pixel_out
    );

    modport slave (
        input  block_shift, color_bits,
        input  h_count_in, v_count_in, active_draw_in, pixel_in,
        output h_count_out, v_count_out, active_draw_out, pixel_out
    );

endinterface

// File: rtl/video_mosaic_fx_line_buffer_ram.sv
// line_buffer_ram
// Simple dual-port RAM holding one line of source pixels for the mosaic
// stage. One write port, one read port, registered read (data one cycle after
// the address). No reset so it maps onto block RAM; contents are undefined
// until written.
//   clk       : clock
//   wr_en_i   : write strobe
//   wr_addr_i : write address
//   wr_data_i : write data
//   rd_en_i   : read strobe
//   rd_addr_i : read address
//   rd_data_o : read data, valid the cycle after rd_en_i
module line_buffer_ram #(
    parameter int DEPTH  = 1280,
    parameter int WIDTH  = 24,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/video_mosaic_fx.sv
// video_mosaic_fx
// Crush slot of the video effect chain: pixelates the picture into square
// blocks of 2^block_shift pixels (each block shows its top-left pixel) and
// posterizes every channel to color_bits bits. Parameters are taken only at
// the first active pixel of a frame so a frame never tears. Fixed 3-cycle
// latency on every output, no stalls.
//   clk   : pixel clock
//   rst_n : synchronous active-low reset
//   vif   : stream/parameter interface (slave modport)
//
// Pipeline:
//   S1 : registered input beat, source value, buffer write/read issue
//   S2 : line-buffer read data arrives; S1 payload delayed
//   S3 : pick buffer data or source, quantize, register outputs
module video_mosaic_fx #(
    parameter int H_ACTIVE = video_fx_pkg::H_ACTIVE,
    parameter int V_ACTIVE = video_fx_pkg::V_ACTIVE
) (
    input  logic             clk,
    input  logic             rst_n,
    video_mosaic_fx_if.slave vif
);
    import video_fx_pkg::*;

    localparam logic [HC_W-1:0] H_LIM = HC_W'(H_ACTIVE);
    localparam logic [VC_W-1:0] V_LIM = VC_W'(V_ACTIVE);

    video_beat_t      beat_in;
    logic             frame_start;
    logic [SH_W-1:0]  sh_q, sh_d;
    logic [CB_W-1:0]  cb_q, cb_d;
    logic [HC_W-1:0]  blk_mask;
    logic             hold_h;
    logic             rep_v;
    logic             in_frame;
    logic [PIX_W-1:0] held_q, held_d;
    logic [PIX_W-1:0] src;

    mosaic_stage_t    s1_q, s1_d;
    logic             s1_wr_q, s1_wr_d;
    mosaic_stage_t    s2_q, s2_d;
    logic [PIX_W-1:0] rd_data;
    logic [PIX_W-1:0] pix_sel;
    video_beat_t      out_q, out_d;

    assign beat_in = {vif.h_count_in, vif.v_count_in, vif.active_draw_in, vif.pixel_in};

    always_comb begin
        frame_start = beat_in.active_draw
                      && (beat_in.h_count == '0)
                      && (beat_in.v_count == '0);

        // The frame-start pixel already uses the newly latched parameters,
        // so the next-state value doubles as the effective value this cycle.
        sh_d = sh_q;
        cb_d = cb_q;
        if (frame_start) begin
            sh_d = clamp_shift(vif.block_shift);
            cb_d = decode_bits(vif.color_bits);
        end

        blk_mask = ~({HC_W{1'b1}} << sh_d);
        hold_h   = |(beat_in.h_count & blk_mask);
        rep_v    = |(beat_in.v_count & blk_mask[VC_W-1:0]);
        in_frame = (beat_in.h_count < H_LIM) && (beat_in.v_count < V_LIM);

        // Horizontal replication: the first column of a block is captured and
        // reused for the rest of the block on the same line.
        src    = hold_h ? held_q : beat_in.pixel;
        held_d = held_q;
        if (beat_in.active_draw && !hold_h) begin
            held_d = beat_in.pixel;
        end

        // Vertical replication: the first row of a block band writes the line
        // buffer, the remaining rows read it back. rep_v is constant across a
        // line, so write and read never collide on one address.
        s1_d.beat    = beat_in;
        s1_d.src     = src;
        s1_d.use_buf = beat_in.active_draw && rep_v && in_frame;
        s1_d.cb      = cb_d;
        s1_wr_d      = beat_in.active_draw && !rep_v && in_frame;

        s2_d = s1_q;

        // Blanking samples leave the stage untouched.
        pix_sel = s2_q.beat.pixel;
        if (s2_q.beat.active_draw) begin
            pix_sel = quantize(s2_q.use_buf ? rd_data : s2_q.src, s2_q.cb);
        end

        out_d       = s2_q.beat;
        out_d.pixel = pix_sel;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q    <= '0;
            cb_q    <= 4'd8;
            held_q  <= '0;
            s1_q    <= '0;
            s1_wr_q <= 1'b0;
            s2_q    <= '0;
            out_q   <= '0;
        end else begin
            sh_q    <= sh_d;
            cb_q    <= cb_d;
            held_q  <= held_d;
            s1_q    <= s1_d;
            s1_wr_q <= s1_wr_d;
            s2_q    <= s2_d;
            out_q   <= out_d;
        end
    end

    line_buffer_ram #(
        .DEPTH  (H_ACTIVE),
        .WIDTH  (PIX_W),
        .ADDR_W (HC_W)
    ) u_line_buffer (
        .clk       (clk),
        .wr_en_i   (s1_wr_q),
        .wr_addr_i (s1_q.beat.h_count),
        .wr_data_i (s1_q.src),
        .rd_en_i   (s1_q.use_buf),
        .rd_addr_i (s1_q.beat.h_count),
        .rd_data_o (rd_data)
    );

    assign vif.h_count_out     = out_q.h_count;
    assign vif.v_count_out     = out_q.v_count;
    assign vif.active_draw_out = out_q.active_draw;
    assign vif.pixel_out       = out_q.pixel;

endmodule

// File: tb/tb_video_mosaic_fx.sv
// tb_video_mosaic_fx
// Drives short raster fragments (block-aligned line segments plus blanking)
// through video_mosaic_fx and compares every output sample with a reference
// built from the effect's rules: each active pixel shows the quantized
// top-left pixel of its block, as recorded for the current frame.
module tb_video_mosaic_fx;
    import video_fx_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    video_mosaic_fx_if vif ();

    video_mosaic_fx #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vif   (vif)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    string       phase    = "init";

    int          m_sh;
    int          m_cb;
    logic [23:0] frame_px [int];
    video_beat_t exp_q [$];

    function automatic int px_key(input int v, input int h);
        return v * 4096 + h;
    endfunction

    function automatic logic [23:0] ref_quant(input logic [23:0] p, input int bits);
        logic [23:0] r;
        int drop;
        drop = 8 - bits;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            int ch;
            ch = int'((p >> (8 * c)) & 24'hFF);
            ch = (ch >> drop) << drop;
            r[8*c +: 8] = 8'(ch);
        end
        return r;
    endfunction

    // One clock of stimulus; the sample leaving the DUT after this edge is
    // checked against the expectation queued three samples earlier.
    task automatic step(input logic rst, input int h, input int v,
                        input logic act, input logic [23:0] px);
        video_beat_t e;
        video_beat_t obs;
        int          blk;
        int          k0;
        rst_n              = rst;
        vif.h_count_in     = HC_W'(h);
        vif.v_count_in     = VC_W'(v);
        vif.active_draw_in = act;
        vif.pixel_in       = px;
        if (!rst) begin
            m_sh = 0;
            m_cb = 8;
            exp_q.delete();
            repeat (3) exp_q.push_back('0);
        end else begin
            if (act && h == 0 && v == 0) begin
                m_sh = (int'(vif.block_shift) > 5) ? 5 : int'(vif.block_shift);
                m_cb = (vif.color_bits == 3'd0) ? 8 : int'(vif.color_bits);
                frame_px.delete();
            end
            e.h_count     = HC_W'(h);
            e.v_count     = VC_W'(v);
            e.active_draw = act;
            e.pixel       = px;
            if (act) begin
                frame_px[px_key(v, h)] = px;
                blk = 1 << m_sh;
                k0  = px_key((v / blk) * blk, (h / blk) * blk);
                if (frame_px.exists(k0)) e.pixel = ref_quant(frame_px[k0], m_cb);
                else                     e.pixel = 'x;
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (exp_q.size() == 3) begin
            e   = exp_q.pop_front();
            obs = {vif.h_count_out, vif.v_count_out, vif.active_draw_out, vif.pixel_out};
            n_checks++;
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s h=%0d v=%0d: observed h=%0d v=%0d act=%b px=%h expected h=%0d v=%0d act=%b px=%h",
                       phase, e.h_count, e.v_count, obs.h_count, obs.v_count, obs.active_draw,
                       obs.pixel, e.h_count, e.v_count, e.active_draw, e.pixel);
            end
        end
    endtask

    // Active segment of a line followed by a few blanking samples.
    // mode 0: random pixels, 1: pixel = h, 2: fixed pixel.
    task automatic drive_line(input int v, input int h0, input int n, input int mode,
                              input logic [23:0] fixed, input int rst_at);
        for (int i = 0; i < n; i++) begin
            int          h;
            logic [23:0] p;
            h = h0 + i;
            case (mode)
                0:       p = 24'($urandom);
                1:       p = 24'(h);
                default: p = fixed;
            endcase
            step(h != rst_at, h, v, 1'b1, p);
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b1, H_ACTIVE + k, v, 1'b0, 24'($urandom));
        end
    endtask

    initial begin
        vif.block_shift = 3'd0;
        vif.color_bits  = 3'd0;

        phase = "reset";
        for (int i = 0; i < 4; i++) step(1'b0, 0, 0, 1'b0, 24'($urandom));
        for (int i = 0; i < 3; i++) step(1'b1, H_ACTIVE + i, 0, 1'b0, 24'($urandom));

        phase = "passthrough";
        vif.block_shift = 3'd0;
        vif.color_bits  = 3'd0;
        for (int v = 0; v < 6; v++) drive_line(v, 0, 48, 0, 24'h0, -1);

        phase = "mosaic4x4";
        vif.block_shift = 3'd2;
        drive_line(0, 0, 16, 1, 24'h0, -1);
        for (int v = 1; v < 8; v++) drive_line(v, 0, 16, 0, 24'h0, -1);

        phase = "posterize1";
        vif.block_shift = 3'd0;
        vif.color_bits  = 3'd1;
        drive_line(0, 0, 8, 2, 24'h7F80FF, -1);
        drive_line(1, 0, 16, 0, 24'h0, -1);

        phase = "posterize4";
        vif.color_bits = 3'd4;
        drive_line(0, 0, 8, 2, 24'h12ABEF, -1);
        drive_line(1, 0, 16, 0, 24'h0, -1);

        phase = "clamp_edge";
        vif.block_shift = 3'd7;
        vif.color_bits  = 3'd0;
        drive_line(0, 0, 32, 0, 24'h0, -1);
        for (int v = 704; v < 720; v++) drive_line(v, 1248, 32, 0, 24'h0, -1);

        phase = "frame_latch";
        vif.block_shift = 3'd0;
        for (int v = 0; v < 4; v++) drive_line(v, 0, 16, 0, 24'h0, -1);
        vif.block_shift = 3'd3;
        for (int v = 300; v < 304; v++) drive_line(v, 0, 16, 0, 24'h0, -1);
        for (int v = 0; v < 10; v++) drive_line(v, 0, 16, 0, 24'h0, -1);

        phase = "reset_midframe";
        vif.color_bits = 3'd2;
        drive_line(0, 0, 16, 0, 24'h0, -1);
        for (int v = 352; v < 360; v++) drive_line(v, 632, 24, 0, 24'h0, -1);
        drive_line(360, 632, 24, 0, 24'h0, 640);
        for (int v = 361; v < 364; v++) drive_line(v, 632, 24, 0, 24'h0, -1);
        phase = "after_reset_frame";
        for (int v = 0; v < 9; v++) drive_line(v, 0, 16, 0, 24'h0, -1);

        for (int f = 0; f < 4; f++) begin
            phase = $sformatf("random_frame%0d", f);
            vif.block_shift = 3'($urandom_range(0, 7));
            vif.color_bits  = 3'($urandom_range(0, 7));
            for (int v = 0; v < 16; v++) drive_line(v, 0, 64, 0, 24'h0, -1);
        end

        phase = "flush";
        for (int i = 0; i < 3; i++) step(1'b1, H_ACTIVE + 8 + i, 0, 1'b0, 24'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
